write: RTL
==========

# c_drain_io_l3_out_serialize_c_m_axi_write_tracker

Write-side companion to the drain module's m_axi register slices. It accepts write-burst requests from the serializer, presents them on the AXI AW channel through a one-entry registered stage, and bounds the number of in-flight bursts with a credit counter. It also consumes the returning B-channel responses, reporting per-burst completion, a sticky error flag and an idle indication so the kernel knows when its output has been flushed.

## Interface
- ADDR_WIDTH, 64: AW address width
- LEN_WIDTH, 8: AW burst-length width (AXI4 awlen encoding, beats-1)
- MAX_OUTSTANDING, 16: maximum AW handshakes without a B response; 1..2^CNT_WIDTH-1
- CNT_WIDTH, 5: width of the outstanding counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_addr  in  ADDR_WIDTH  burst start address
- req_len  in  LEN_WIDTH  burst length, beats-1
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- m_awaddr  out  ADDR_WIDTH  registered address
- m_awlen  out  LEN_WIDTH  registered length
- m_awvalid  out  1  AW valid
- m_awready  in  1  AW ready
- m_bresp  in  2  write response code
- m_bvalid  in  1  B valid
- m_bready  out  1  B ready
- done  out  1  one-cycle pulse per accepted B response
- err  out  1  sticky response/protocol error
- err_clr  in  1  clears err
- outstanding  out  CNT_WIDTH  current in-flight burst count
- idle  out  1  no held request and outstanding == 0

## Operation
- AW stage, two states: EMPTY (no held request), FULL (request held in m_awaddr/m_awlen).
- credit_ok = (outstanding < MAX_OUTSTANDING).
- m_awvalid = FULL & credit_ok. Credit only increases while FULL without an AW handshake, so m_awvalid never drops before its handshake.
- aw_fire = m_awvalid & m_awready.
- req_ready = EMPTY | aw_fire. This is combinational from m_awready, which allows back-to-back transfers.
- Request acceptance: capture req_addr/req_len. EMPTY goes to FULL; FULL with aw_fire stays FULL with the new request.
- aw_fire without a new request: FULL goes to EMPTY.
- Payload registers load only on request acceptance. Their values are don't-care while EMPTY.
- m_bready is a register: 0 during reset, 1 in every cycle after reset.
- b_fire = m_bvalid & m_bready.
- Outstanding counter:
  - +1 on aw_fire alone; −1 on b_fire alone.
  - Unchanged when both fire in the same cycle.
  - b_fire with outstanding == 0 is a protocol error: the counter stays 0 (no underflow) and err is set.
- done is registered and equals b_fire of the previous cycle. It pulses even for the protocol-error case.
- err is set when b_fire & m_bresp[1] (SLVERR/DECERR) or on underflow. EXOKAY and OKAY do not set it.
- err_clr clears err. A set in the same cycle wins over err_clr.
- idle = EMPTY & (outstanding == 0), combinational from registers.
- Reset mid-operation discards the held request and in-flight count without waiting for responses. Upstream must re-issue.

## Timing
- Reset values:
  - 0: m_awvalid, m_bready, done, err, outstanding.
  - State EMPTY, so req_ready = 1 and idle = 1.
- Request accepted at edge N: m_awvalid high in cycle N+1 if credit_ok.
- Sustained throughput is 1 request/cycle while m_awready = 1 and credit is available.
- Counter updates at the edge ending the aw_fire/b_fire cycle.
- Saturation: at outstanding == MAX_OUTSTANDING, m_awvalid = 0. A held request stalls and req_ready = 0.
  - A b_fire at edge M makes the counter MAX−1.
  - m_awvalid reasserts in cycle M+1.
- done is asserted in the cycle after b_fire.
- err is visible in the cycle after the triggering b_fire.
- idle asserts in the cycle after the final b_fire when EMPTY.

## Test plan
- Reset → req_ready=1, m_awvalid=0, m_bready=0, idle=1. One cycle after reset release → m_bready=1.
- Request 0x1000/len 15 with m_awready=1 → m_awvalid next cycle with awaddr=0x1000, awlen=15; outstanding=1; OKAY B response → done pulse one cycle later, outstanding=0, idle=1.
- MAX_OUTSTANDING=4, m_awready=1, 6 back-to-back requests, no B responses:
  - 4 AW handshakes, then m_awvalid=0, req_ready=0, outstanding=4.
  - One B response → exactly one further AW handshake, outstanding back to 4.
- aw_fire and b_fire in the same cycle at outstanding=2 → outstanding remains 2; done pulses.
- B response with bresp=2'b10 → err=1 and stays set. err_clr with a simultaneous bresp=2'b11 → err stays 1. err_clr alone → err=0.
- b_fire at outstanding=0 → outstanding stays 0, err=1, done pulses. Separately: reset asserted with outstanding=3 and FULL → outstanding=0, m_awvalid=0, idle=1 after reset.

Source files
------------

// File: rtl/write_if.sv
// Request and AXI write-address/response signals shared by the write tracker
// and its neighbours.
//   req_*   : burst request from the serializer (addr, len = beats-1, valid/ready)
//   m_aw*   : AXI AW channel (addr, len, valid/ready)
//   m_b*    : AXI B channel (resp, valid/ready)
// modport master : the tracker (drives AW, accepts requests, consumes B)
// modport slave  : the environment side (issues requests, AXI slave)
interface write_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [LEN_WIDTH-1:0]  m_awlen;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    input  req_addr, req_len, req_valid, m_awready, m_bresp, m_bvalid,
    output req_ready, m_awaddr, m_awlen, m_awvalid, m_bready
  );

  modport slave (
    output req_addr, req_len, req_valid, m_awready, m_bresp, m_bvalid,
    input  req_ready, m_awaddr, m_awlen, m_awvalid, m_bready
  );
endinterface

// File: rtl/write.sv
// AXI write-burst tracker: holds one burst request in a registered AW stage,
// limits in-flight bursts with a credit counter and consumes B responses.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : request / AW / B signals (write_if.master)
//   done        : one-cycle pulse per accepted B response
//   err         : sticky error (SLVERR/DECERR or B with nothing outstanding)
//   err_clr     : clears err (a simultaneous set wins)
//   outstanding : bursts issued on AW without a B response yet
//   idle        : no held request and nothing outstanding
module write #(
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  write_if.master              bus,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 idle
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  bready_q, bready_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic credit_ok, aw_valid, aw_fire, req_ready, req_acc, b_fire, underflow;

  always_comb begin
    credit_ok = cnt_q < CNT_WIDTH'(MAX_OUTSTANDING);
    aw_valid  = (state_q == FULL) && credit_ok;
    aw_fire   = aw_valid && bus.m_awready;
    // A request may enter in the same cycle the held one leaves on AW.
    req_ready = (state_q == EMPTY) || aw_fire;
    req_acc   = bus.req_valid && req_ready;
    b_fire    = bus.m_bvalid && bready_q;
    underflow = b_fire && (cnt_q == '0);

    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    bready_d = 1'b1;
    done_d   = b_fire;
    err_d    = err_q;

    if (req_acc) begin
      state_d = FULL;
      addr_d  = bus.req_addr;
      len_d   = bus.req_len;
    end else if (aw_fire) begin
      state_d = EMPTY;
    end

    case ({aw_fire, b_fire})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = underflow ? cnt_q : cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase

    if (b_fire && (bus.m_bresp[1] || underflow)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      bready_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bready_q <= bready_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
    // Payload is meaningless while EMPTY, so it is not reset.
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  assign bus.req_ready = req_ready;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awlen   = len_q;
  assign bus.m_awvalid = aw_valid;
  assign bus.m_bready  = bready_q;
  assign done          = done_q;
  assign err           = err_q;
  assign outstanding   = cnt_q;
  assign idle          = (state_q == EMPTY) && (cnt_q == '0);

endmodule
